pipe_stall_ctrl: RTL and testbench

- Central pipeline-control sequencer for the 5-stage processor (F, D, X, M, W).
- Combines three hazard sources into one consistent set of latch enables, flushes and bubbles:
  - load-use hazard indication from the decode-stage detector;
  - multi-cycle multiply/divide occupancy;
  - taken branch/jump resolution from X.
- Owns the multdiv start/abort handshake and a watchdog on multdiv latency.
- Sits beside the PC and pipeline latches. It is the only driver of their enables.

---
 rtl/pipe_stall_ctrl_pkg.sv | 71 +++++++
 rtl/pipe_stall_ctrl_wait_timer.sv | 32 +++
 rtl/pipe_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: state encodings, opcode constants
// (also used by the decode-stage hazard detector) and control-word helpers.
package pipe_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_LW_HOLD = 2'b01,
      ST_MD_WAIT = 2'b10,
      ST_BAD     = 2'b11
   } ctrl_state_t;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW   = 5'b01000;

   typedef struct packed {
      logic pc_en;
      logic fd_en;
      logic dx_en;
      logic xm_en;
      logic mw_en;
      logic fd_flush;
      logic dx_bubble;
      logic xm_bubble;
      logic md_go;
      logic md_abort;
   } ctrl_out_t;

   localparam ctrl_out_t CTRL_IDLE = '0;

   function automatic ctrl_out_t ctrl_flow();
      ctrl_out_t c;
      c       = CTRL_IDLE;
      c.pc_en = 1'b1;
      c.fd_en = 1'b1;
      c.dx_en = 1'b1;
      c.xm_en = 1'b1;
      c.mw_en = 1'b1;
      return c;
   endfunction

   // Squash the two younger instructions behind a taken branch.
   function automatic ctrl_out_t ctrl_branch();
      ctrl_out_t c;
      c           = ctrl_flow();
      c.fd_flush  = 1'b1;
      c.dx_bubble = 1'b1;
      return c;
   endfunction

   // Front end frozen while multdiv owns X; W keeps draining.
   function automatic ctrl_out_t ctrl_md_stall();
      ctrl_out_t c;
      c           = CTRL_IDLE;
      c.xm_en     = 1'b1;
      c.xm_bubble = 1'b1;
      c.mw_en     = 1'b1;
      return c;
   endfunction

   function automatic ctrl_out_t ctrl_lw_stall();
      ctrl_out_t c;
      c           = CTRL_IDLE;
      c.dx_en     = 1'b1;
      c.dx_bubble = 1'b1;
      c.xm_en     = 1'b1;
      c.mw_en     = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_wait_timer.sv
// pipe_wait_timer: saturating multdiv wait counter with clear/enable and an
// expired flag raised when the count reaches MD_TIMEOUT.
module pipe_wait_timer
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MD_TIMEOUT);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use, multdiv and branch hazards
// into latch enables. Optional stall_cycles counter under PIPE_STALL_CNT_EN.
//
// state      | meaning
// RUN        | normal flow, hazards evaluated (branch > multdiv > load-use)
// LW_HOLD    | single recovery cycle after a load-use bubble
// MD_WAIT    | front end frozen until multdiv ready or watchdog expiry
// (11)       | illegal, returns to RUN with all enables set
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        lw_hazard,
   input  logic        md_start,
   input  logic        md_ready,
   input  logic        branch_taken,
   output logic        pc_en,
   output logic        fd_en,
   output logic        dx_en,
   output logic        xm_en,
   output logic        mw_en,
   output logic        fd_flush,
   output logic        dx_bubble,
   output logic        xm_bubble,
   output logic        md_go,
   output logic        md_abort,
   output logic        md_timeout,
   output logic [1:0]  ctrl_state
`ifdef PIPE_STALL_CNT_EN
  ,output logic [31:0] stall_cycles
`endif
);

   localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

   ctrl_state_t state;
   ctrl_state_t nxt;
   ctrl_out_t   co;
   logic        tmr_clr;
   logic        tmr_en;
   logic        tmr_expired;
   logic        timeout_set;

   pipe_wait_timer #(
      .MD_TIMEOUT (MD_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_wait_timer (
      .clock   (clock),
      .reset   (reset),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      nxt         = state;
      co          = CTRL_IDLE;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
      timeout_set = 1'b0;
      case (state)
         ST_RUN, ST_LW_HOLD: begin
            if (branch_taken) begin
               co  = ctrl_branch();
               nxt = ST_RUN;
            end else if ((state == ST_RUN) && md_start) begin
               co       = ctrl_md_stall();
               co.md_go = 1'b1;
               tmr_en   = 1'b1;
               nxt      = ST_MD_WAIT;
            end else if ((state == ST_RUN) && lw_hazard) begin
               co  = ctrl_lw_stall();
               nxt = ST_LW_HOLD;
            end else begin
               co  = ctrl_flow();
               nxt = ST_RUN;
            end
         end
         ST_MD_WAIT: begin
            if (md_ready) begin
               co      = ctrl_flow();
               tmr_clr = 1'b1;
               nxt     = ST_RUN;
            end else if (tmr_expired) begin
               // Result never arrived: release the pipe with a nop in X/M.
               co           = ctrl_flow();
               co.xm_bubble = 1'b1;
               co.md_abort  = 1'b1;
               timeout_set  = 1'b1;
               tmr_clr      = 1'b1;
               nxt          = ST_RUN;
            end else begin
               co     = ctrl_md_stall();
               tmr_en = 1'b1;
            end
         end
         default: begin
            co      = ctrl_flow();
            tmr_clr = 1'b1;
            nxt     = ST_RUN;
         end
      endcase
      if (!reset) begin
         co = CTRL_IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_RUN;
         md_timeout <= 1'b0;
      end else begin
         state <= nxt;
         if (timeout_set) begin
            md_timeout <= 1'b1;
         end
      end
   end

   assign pc_en      = co.pc_en;
   assign fd_en      = co.fd_en;
   assign dx_en      = co.dx_en;
   assign xm_en      = co.xm_en;
   assign mw_en      = co.mw_en;
   assign fd_flush   = co.fd_flush;
   assign dx_bubble  = co.dx_bubble;
   assign xm_bubble  = co.xm_bubble;
   assign md_go      = co.md_go;
   assign md_abort   = co.md_abort;
   assign ctrl_state = state;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (!co.pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;
`else
   // Stall statistics not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: instance A uses the default watchdog,
// instance B a short one (4) for the timeout cases.
module tb_pipe_stall_ctrl;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;
   logic lw_a, ms_a, mr_a, bt_a;
   logic lw_b, ms_b, mr_b, bt_b;

   logic pc_en_a, fd_en_a, dx_en_a, xm_en_a, mw_en_a, fd_flush_a, dx_bubble_a;
   logic xm_bubble_a, md_go_a, md_abort_a, md_timeout_a;
   logic [1:0] ctrl_state_a;
   logic pc_en_b, fd_en_b, dx_en_b, xm_en_b, mw_en_b, fd_flush_b, dx_bubble_b;
   logic xm_bubble_b, md_go_b, md_abort_b, md_timeout_b;
   logic [1:0] ctrl_state_b;
`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_a, stall_b;
`endif

   pipe_stall_ctrl u_dut_a (
      .clock(clock), .reset(reset),
      .lw_hazard(lw_a), .md_start(ms_a), .md_ready(mr_a), .branch_taken(bt_a),
      .pc_en(pc_en_a), .fd_en(fd_en_a), .dx_en(dx_en_a), .xm_en(xm_en_a), .mw_en(mw_en_a),
      .fd_flush(fd_flush_a), .dx_bubble(dx_bubble_a), .xm_bubble(xm_bubble_a),
      .md_go(md_go_a), .md_abort(md_abort_a), .md_timeout(md_timeout_a),
      .ctrl_state(ctrl_state_a)
`ifdef PIPE_STALL_CNT_EN
     ,.stall_cycles(stall_a)
`endif
   );

   pipe_stall_ctrl #(.MD_TIMEOUT(4)) u_dut_b (
      .clock(clock), .reset(reset),
      .lw_hazard(lw_b), .md_start(ms_b), .md_ready(mr_b), .branch_taken(bt_b),
      .pc_en(pc_en_b), .fd_en(fd_en_b), .dx_en(dx_en_b), .xm_en(xm_en_b), .mw_en(mw_en_b),
      .fd_flush(fd_flush_b), .dx_bubble(dx_bubble_b), .xm_bubble(xm_bubble_b),
      .md_go(md_go_b), .md_abort(md_abort_b), .md_timeout(md_timeout_b),
      .ctrl_state(ctrl_state_b)
`ifdef PIPE_STALL_CNT_EN
     ,.stall_cycles(stall_b)
`endif
   );

   // {pc,fd,dx,xm,mw enables, fd_flush,dx_bubble,xm_bubble, md_go, md_abort, md_timeout, state}
   logic [12:0] obs_a, obs_b;
   assign obs_a = {pc_en_a, fd_en_a, dx_en_a, xm_en_a, mw_en_a, fd_flush_a, dx_bubble_a,
                   xm_bubble_a, md_go_a, md_abort_a, md_timeout_a, ctrl_state_a};
   assign obs_b = {pc_en_b, fd_en_b, dx_en_b, xm_en_b, mw_en_b, fd_flush_b, dx_bubble_b,
                   xm_bubble_b, md_go_b, md_abort_b, md_timeout_b, ctrl_state_b};

   localparam logic [4:0] E_ALL = 5'b11111;
   localparam logic [4:0] E_MD  = 5'b00011;
   localparam logic [4:0] E_LW  = 5'b00111;
   localparam logic [4:0] E_OFF = 5'b00000;

   typedef struct {
      bit          sel;
      logic [12:0] e;
      logic [31:0] stall;
      string       tag;
   } sb_t;

   sb_t         sbq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] stall_tally = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [12:0] ev(input logic [4:0] en, input logic [2:0] nop,
                                      input logic go, input logic ab, input logic to,
                                      input logic [1:0] st);
      return {en, nop, go, ab, to, st};
   endfunction

   task automatic push(input bit sel, input logic [12:0] e, input string tag);
      sb_t s;
      s.sel   = sel;
      s.e     = e;
      s.stall = stall_tally;
      s.tag   = tag;
      sbq.push_back(s);
      if (!sel && reset && !e[12]) stall_tally = stall_tally + 32'd1;
   endtask

   task automatic step(input bit sel, input logic lw, input logic ms, input logic mr,
                       input logic bt, input logic [12:0] e, input string tag);
      @(posedge clock);
      #1;
      {lw_a, ms_a, mr_a, bt_a} = sel ? 4'b0 : {lw, ms, mr, bt};
      {lw_b, ms_b, mr_b, bt_b} = sel ? {lw, ms, mr, bt} : 4'b0;
      push(sel, e, tag);
   endtask

   task automatic rst_step(input logic r, input logic [12:0] e, input string tag);
      @(posedge clock);
      #1;
      reset = r;
      {lw_a, ms_a, mr_a, bt_a} = 4'b0;
      {lw_b, ms_b, mr_b, bt_b} = 4'b0;
      if (!r) stall_tally = '0;
      push(1'b0, e, tag);
   endtask

   always @(negedge clock) begin
      if (sbq.size() != 0) begin
         sb_t s;
         s = sbq.pop_front();
         if (!s.sel) check(s.tag, 32'(obs_a), 32'(s.e));
         else        check(s.tag, 32'(obs_b), 32'(s.e));
`ifdef PIPE_STALL_CNT_EN
         if (!s.sel) check({s.tag, "_stall"}, stall_a, s.stall);
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "bench timed out");
   end

   initial begin
      reset = 1'b0;
      {lw_a, ms_a, mr_a, bt_a} = 4'b0;
      {lw_b, ms_b, mr_b, bt_b} = 4'b0;

      // reset and release
      for (int i = 0; i < 3; i++) rst_step(1'b0, ev(E_OFF, 3'b000, 0, 0, 0, 2'b00), "in_reset");
      rst_step(1'b1, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "release");
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "run_idle");
      step(0, 0, 0, 1, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "rdy_in_run");

      // load-use: one bubble then LW_HOLD ignores the stale hazard
      step(0, 1, 0, 0, 0, ev(E_LW,  3'b010, 0, 0, 0, 2'b00), "lw_stall");
      step(0, 1, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b01), "lw_hold");
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "lw_back");

      // multdiv ready on the 17th wait cycle; other hazards ignored while waiting
      step(0, 0, 1, 0, 0, ev(E_MD, 3'b001, 1, 0, 0, 2'b00), "md_go");
      for (int i = 1; i <= 16; i++)
         step(0, (i == 7), (i == 6), 1'b0, (i == 5), ev(E_MD, 3'b001, 0, 0, 0, 2'b10), "md_wait");
      step(0, 0, 0, 1, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b10), "md_ready");
`ifdef PIPE_STALL_CNT_EN
      @(negedge clock);
      check("stall_18", stall_a, 32'd18);
`endif
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "md_back");

      // branch priority
      step(0, 1, 0, 0, 1, ev(E_ALL, 3'b110, 0, 0, 0, 2'b00), "br_lw");
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "br_lw_next");
      step(0, 0, 1, 0, 1, ev(E_ALL, 3'b110, 0, 0, 0, 2'b00), "br_md");
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "br_md_next");
      step(0, 1, 0, 0, 0, ev(E_LW,  3'b010, 0, 0, 0, 2'b00), "lw_stall2");
      step(0, 0, 0, 0, 1, ev(E_ALL, 3'b110, 0, 0, 0, 2'b01), "hold_br");
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "hold_br_next");

      // watchdog expiry on instance B (MD_TIMEOUT=4)
      step(1, 0, 1, 0, 0, ev(E_MD, 3'b001, 1, 0, 0, 2'b00), "b_go");
      for (int i = 1; i <= 3; i++)
         step(1, 0, 0, 0, 0, ev(E_MD, 3'b001, 0, 0, 0, 2'b10), "b_wait");
      step(1, 0, 0, 0, 0, ev(E_ALL, 3'b001, 0, 1, 0, 2'b10), "b_abort");
      step(1, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 1, 2'b00), "b_sticky");
      step(1, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 1, 2'b00), "b_sticky2");

      // ready on the expiry cycle counts as ready
      step(1, 0, 1, 0, 0, ev(E_MD, 3'b001, 1, 0, 1, 2'b00), "b_go2");
      for (int i = 1; i <= 3; i++)
         step(1, 0, 0, 0, 0, ev(E_MD, 3'b001, 0, 0, 1, 2'b10), "b_wait2");
      step(1, 0, 0, 1, 0, ev(E_ALL, 3'b000, 0, 0, 1, 2'b10), "b_rdy_edge");
      step(1, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 1, 2'b00), "b_back");

      // reset in the middle of a multdiv wait: no abort pulse
      step(0, 0, 1, 0, 0, ev(E_MD, 3'b001, 1, 0, 0, 2'b00), "mid_go");
      step(0, 0, 0, 0, 0, ev(E_MD, 3'b001, 0, 0, 0, 2'b10), "mid_wait");
      step(0, 0, 0, 0, 0, ev(E_MD, 3'b001, 0, 0, 0, 2'b10), "mid_wait");
      rst_step(1'b0, ev(E_OFF, 3'b000, 0, 0, 0, 2'b00), "mid_reset");
      rst_step(1'b1, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "mid_release");
      step(0, 0, 0, 0, 0, ev(E_ALL, 3'b000, 0, 0, 0, 2'b00), "mid_run");

      for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clock);
      @(negedge clock);
      if (sbq.size() != 0) check("drain", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
